clk_div_ctrl: RTL and testbench

Run-time controller for the board's divided clock, driven by the 50 MHz built-in oscillator.
- Owns the divide ratio, start/stop sequencing and glitch-free ratio changes for a square-wave output plus a one-cycle tick enable.
- Sits between the control FSM or user logic, which issues configuration/start/stop, and the slow-clock consumers (display refresh, timers).
- Ratio changes and stops take effect only at period boundaries, so CLKOut never produces a runt pulse.

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_core.sv | 40 ++++
 rtl/clk_div_ctrl.sv | 136 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the divided-clock controller: FSM encoding and board constants.
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   localparam int CLK_DIV_WIDTH        = 32;
   localparam int CLK_HZ               = 50000000;
   localparam int CLK_DIV_DEFAULT_HALF = CLK_HZ / 2;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter with terminal-count compare; toggles the divided clock and pulses tick on each wrap.
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int WIDTH = CLK_DIV_WIDTH
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] half,
   output logic             tc,
   output logic             clk_out,
   output logic             tick
);

   logic [WIDTH-1:0] count_reg;

   // Equality compare is safe because half only changes on a wrap, so count never overshoots.
   assign tc = enable && !clear && (count_reg == (half - WIDTH'(1)));

   always_ff @(posedge clk) begin
      if (srst || clear) begin
         count_reg <= '0;
         clk_out   <= 1'b0;
         tick      <= 1'b0;
      end else if (enable) begin
         tick <= tc;
         if (tc) begin
            count_reg <= '0;
            clk_out   <= ~clk_out;
         end else begin
            count_reg <= count_reg + WIDTH'(1);
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: start/stop sequencing and glitch-free half-period changes.
// Optional auto-stop after a burst of periods is enabled by defining CLK_DIV_CTRL_BURST_EN.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int WIDTH        = CLK_DIV_WIDTH,
   parameter int DEFAULT_HALF = CLK_DIV_DEFAULT_HALF
) (
   input  logic             CLKIn,
   input  logic             Reset,
   input  logic             CfgValid,
   input  logic [WIDTH-1:0] CfgHalf,
   output logic             CfgReady,
   input  logic             Start,
   input  logic             Stop,
   output logic             Running,
   output logic             CLKOut,
`ifdef CLK_DIV_CTRL_BURST_EN
   input  logic [15:0]      BurstLen,
   output logic             Done,
`endif
   output logic             Tick
);

   state_t           state_reg;
   logic [WIDTH-1:0] half_reg;
   logic [WIDTH-1:0] shadow_reg;
   logic             pending_reg;
   logic             tc;
   logic             stop_now;
   logic             cfg_fire;
   logic [WIDTH-1:0] cfg_val;

   assign cfg_fire = CfgValid && CfgReady;
   assign cfg_val  = (CfgHalf == '0) ? WIDTH'(1) : CfgHalf;
   // Stopping during the low phase just truncates it; the output is already low.
   assign stop_now = (state_reg == RUN) && Stop && !CLKOut;

`ifdef CLK_DIV_CTRL_BURST_EN
   logic [15:0] burst_len_reg;
   logic [15:0] burst_cnt_reg;
   logic        burst_last;

   assign burst_last = (burst_len_reg != 16'd0) && (burst_cnt_reg == burst_len_reg - 16'd1);
`endif

   clk_div_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk     (CLKIn),
      .srst    (Reset),
      .enable  (state_reg != IDLE),
      .clear   ((state_reg == IDLE) || stop_now),
      .half    (half_reg),
      .tc      (tc),
      .clk_out (CLKOut),
      .tick    (Tick)
   );

   always_ff @(posedge CLKIn) begin
      if (Reset) begin
         state_reg   <= IDLE;
         half_reg    <= WIDTH'(DEFAULT_HALF);
         shadow_reg  <= '0;
         pending_reg <= 1'b0;
         CfgReady    <= 1'b1;
         Running     <= 1'b0;
`ifdef CLK_DIV_CTRL_BURST_EN
         burst_len_reg <= '0;
         burst_cnt_reg <= '0;
         Done          <= 1'b0;
`endif
      end else begin
`ifdef CLK_DIV_CTRL_BURST_EN
         Done <= 1'b0;
`endif
         if (cfg_fire && state_reg == IDLE) begin
            half_reg <= cfg_val;
         end else if (cfg_fire) begin
            shadow_reg  <= cfg_val;
            pending_reg <= 1'b1;
            CfgReady    <= 1'b0;
         end else if (pending_reg && (state_reg == IDLE || tc || stop_now)) begin
            half_reg    <= shadow_reg;
            pending_reg <= 1'b0;
            CfgReady    <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (Start && !Stop) begin
                  state_reg <= RUN;
                  Running   <= 1'b1;
`ifdef CLK_DIV_CTRL_BURST_EN
                  burst_len_reg <= BurstLen;
                  burst_cnt_reg <= '0;
`endif
               end
            end
            RUN: begin
               if (Stop) begin
                  // A stop landing on the falling wrap completes right there.
                  if (!CLKOut || tc) begin
                     state_reg <= IDLE;
                     Running   <= 1'b0;
                  end else begin
                     state_reg <= STOPPING;
                  end
               end
`ifdef CLK_DIV_CTRL_BURST_EN
               else if (tc && CLKOut) begin
                  if (burst_last) begin
                     state_reg <= IDLE;
                     Running   <= 1'b0;
                     Done      <= 1'b1;
                  end else begin
                     burst_cnt_reg <= burst_cnt_reg + 16'd1;
                  end
               end
`endif
            end
            STOPPING: begin
               if (tc) begin
                  state_reg <= IDLE;
                  Running   <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               Running   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: vector table, corner-case sequences, randomized run against a phase model.
module tb_clk_div_ctrl;

   localparam int DEF_HALF = 7;

   logic        clk;
   logic        rst;
   logic        cfg_valid;
   logic [31:0] cfg_half;
   logic        cfg_ready;
   logic        start;
   logic        stop;
   logic        running;
   logic        clk_out;
   logic        tick;
`ifdef CLK_DIV_CTRL_BURST_EN
   logic [15:0] burst_len;
   logic        done;
   initial burst_len = 16'd0;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: phase-elapsed view of the output.
   bit m_on, m_drain, m_level, m_tick, m_ready, m_pend;
   int m_elapsed, m_half, m_shadow;

   typedef struct {
      logic        start;
      logic        stop;
      logic        cv;
      logic [31:0] ch;
      logic        e_clk;
      logic        e_tick;
      logic        e_run;
      logic        e_rdy;
   } vec_t;

   vec_t vecs[15];

   clk_div_ctrl #(
      .WIDTH(32),
      .DEFAULT_HALF(DEF_HALF)
   ) dut (
      .CLKIn    (clk),
      .Reset    (rst),
      .CfgValid (cfg_valid),
      .CfgHalf  (cfg_half),
      .CfgReady (cfg_ready),
      .Start    (start),
      .Stop     (stop),
      .Running  (running),
      .CLKOut   (clk_out),
`ifdef CLK_DIV_CTRL_BURST_EN
      .BurstLen (burst_len),
      .Done     (done),
`endif
      .Tick     (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0b required %0b", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   task automatic model_commit();
      if (m_pend) begin
         m_half  = m_shadow;
         m_pend  = 1'b0;
         m_ready = 1'b1;
      end
   endtask

   task automatic model_step();
      bit accept;
      int val;
      if (rst) begin
         m_on = 0; m_drain = 0; m_level = 0; m_tick = 0;
         m_ready = 1; m_pend = 0; m_elapsed = 0; m_half = DEF_HALF; m_shadow = 0;
         return;
      end
      accept = cfg_valid && m_ready;
      val    = (cfg_half == 0) ? 1 : int'(cfg_half);
      m_tick = 0;
      if (!m_on) begin
         if (accept) m_half = val;
         else model_commit();
         m_elapsed = 0;
         m_level   = 0;
         if (start && !stop) m_on = 1;
      end else begin
         if (stop && !m_drain && !m_level) begin
            model_commit();
            m_on = 0;
            m_elapsed = 0;
         end else if (m_elapsed + 1 == m_half) begin
            m_level   = !m_level;
            m_tick    = 1;
            m_elapsed = 0;
            model_commit();
            if (m_drain || stop) begin
               m_on = 0;
               m_drain = 0;
            end
         end else begin
            m_elapsed++;
            if (stop) m_drain = 1;
         end
         if (accept) begin
            m_shadow = val;
            m_pend   = 1;
            m_ready  = 0;
         end
      end
   endtask

   // Advance one cycle with the current inputs and compare every output with the model.
   task automatic step_cmp(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check({tag, ".clk_out"}, clk_out, m_level);
      check({tag, ".tick"}, tick, m_tick);
      check({tag, ".running"}, running, m_on);
      check({tag, ".cfg_ready"}, cfg_ready, m_ready);
   endtask

   task automatic idle_inputs();
      rst = 0; start = 0; stop = 0; cfg_valid = 0; cfg_half = 0;
   endtask

   task automatic go_idle(input string tag);
      int n;
      n = 0;
      stop = 1;
      while (running && n < 100) begin
         step_cmp(tag);
         n++;
      end
      stop = 0;
      check({tag, ".idle_reached"}, running, 1'b0);
   endtask

   initial begin
      int n;
      int t0;
      logic prev;

      vecs[0]  = '{0, 0, 1, 32'd3, 0, 0, 0, 1};
      vecs[1]  = '{1, 0, 0, 32'd0, 0, 0, 1, 1};
      vecs[2]  = '{0, 0, 0, 32'd0, 0, 0, 1, 1};
      vecs[3]  = '{0, 0, 0, 32'd0, 0, 0, 1, 1};
      vecs[4]  = '{0, 0, 0, 32'd0, 1, 1, 1, 1};
      vecs[5]  = '{0, 0, 0, 32'd0, 1, 0, 1, 1};
      vecs[6]  = '{0, 0, 0, 32'd0, 1, 0, 1, 1};
      vecs[7]  = '{0, 0, 0, 32'd0, 0, 1, 1, 1};
      vecs[8]  = '{0, 0, 0, 32'd0, 0, 0, 1, 1};
      vecs[9]  = '{0, 0, 0, 32'd0, 0, 0, 1, 1};
      vecs[10] = '{0, 0, 0, 32'd0, 1, 1, 1, 1};
      vecs[11] = '{0, 1, 0, 32'd0, 1, 0, 1, 1};
      vecs[12] = '{0, 0, 0, 32'd0, 1, 0, 1, 1};
      vecs[13] = '{0, 0, 0, 32'd0, 0, 1, 0, 1};
      vecs[14] = '{1, 1, 0, 32'd0, 0, 0, 0, 1};

      idle_inputs();
      rst = 1;
      step_cmp("reset0");
      step_cmp("reset1");
      rst = 0;

      for (int i = 0; i < 15; i++) begin
         start = vecs[i].start; stop = vecs[i].stop;
         cfg_valid = vecs[i].cv; cfg_half = vecs[i].ch;
         model_step();
         @(posedge clk);
         #1;
         $display("txn vec%0d: start=%0b stop=%0b cv=%0b ch=%0d -> clk=%0b tick=%0b run=%0b rdy=%0b",
                  i, start, stop, cfg_valid, cfg_half, clk_out, tick, running, cfg_ready);
         check($sformatf("vec%0d.clk_out", i), clk_out, vecs[i].e_clk);
         check($sformatf("vec%0d.tick", i), tick, vecs[i].e_tick);
         check($sformatf("vec%0d.running", i), running, vecs[i].e_run);
         check($sformatf("vec%0d.cfg_ready", i), cfg_ready, vecs[i].e_rdy);
      end
      idle_inputs();

      // Half=3 running, offer 5 mid-phase: held off until the wrap, then 5-cycle phases.
      start = 1; step_cmp("chg.start"); start = 0;
      step_cmp("chg.mid");
      cfg_valid = 1; cfg_half = 5; step_cmp("chg.offer"); cfg_valid = 0;
      check("chg.ready_low", cfg_ready, 1'b0);
      n = 0;
      while (!tick && n < 20) begin step_cmp("chg.wait"); n++; end
      check("chg.first_wrap_tick", tick, 1'b1);
      check("chg.ready_after_wrap", cfg_ready, 1'b1);
      t0 = n;
      n = 0;
      step_cmp("chg.phase");
      n = 1;
      while (!tick && n < 20) begin step_cmp("chg.phase"); n++; end
      check_int("chg.new_phase_len", n, 5);
      $display("txn change: wait=%0d new_phase=%0d", t0, n);
      go_idle("chg.stop");

      // Half=4, stop right after the rising wrap: drains the high phase.
      cfg_valid = 1; cfg_half = 4; step_cmp("drain.cfg"); cfg_valid = 0;
      start = 1; step_cmp("drain.start"); start = 0;
      n = 0;
      while (!tick && n < 20) begin step_cmp("drain.rise"); n++; end
      check("drain.rose", clk_out, 1'b1);
      stop = 1; step_cmp("drain.stop"); stop = 0;
      check("drain.still_running", running, 1'b1);
      n = 1;
      while (clk_out && n < 20) begin step_cmp("drain.hold"); n++; end
      check_int("drain.fall_delay", n, 4);
      check("drain.fall_tick", tick, 1'b1);
      check("drain.running_off", running, 1'b0);
      $display("txn drain: fall after %0d cycles", n);
      step_cmp("drain.idle");

      // Start+Stop together stays idle; then CfgHalf=0 clamps to 1.
      start = 1; stop = 1; step_cmp("both"); start = 0; stop = 0;
      check("both.running", running, 1'b0);
      check("both.clk_out", clk_out, 1'b0);
      cfg_valid = 1; cfg_half = 0; step_cmp("zero.cfg"); cfg_valid = 0;
      start = 1; step_cmp("zero.start"); start = 0;
      prev = clk_out;
      for (int i = 0; i < 6; i++) begin
         step_cmp("zero.run");
         check($sformatf("zero.toggle%0d", i), clk_out, ~prev);
         prev = clk_out;
      end
      $display("txn clamp: half 0 treated as 1");
      go_idle("zero.stop");

      // Reset while high with a change pending, then default half restored.
      cfg_valid = 1; cfg_half = 6; step_cmp("rst.cfg"); cfg_valid = 0;
      start = 1; step_cmp("rst.start"); start = 0;
      n = 0;
      while (!clk_out && n < 30) begin step_cmp("rst.wait"); n++; end
      check("rst.high", clk_out, 1'b1);
      cfg_valid = 1; cfg_half = 3; step_cmp("rst.pend"); cfg_valid = 0;
      check("rst.pending", cfg_ready, 1'b0);
      rst = 1; step_cmp("rst.assert"); rst = 0;
      check("rst.clk_low", clk_out, 1'b0);
      check("rst.ready", cfg_ready, 1'b1);
      check("rst.running", running, 1'b0);
      start = 1; step_cmp("rst.restart"); start = 0;
      n = 0;
      while (!clk_out && n < 30) begin step_cmp("rst.rise"); n++; end
      check_int("rst.default_half", n, DEF_HALF);
      $display("txn reset: first rise after %0d cycles", n);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         start     = ($urandom_range(0, 7) == 0);
         stop      = ($urandom_range(0, 24) == 0);
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_half  = 32'($urandom_range(0, 6));
         if (rst || (cfg_valid && m_ready) || (start && !m_on) || stop)
            $display("txn rand%0d: rst=%0b start=%0b stop=%0b cv=%0b ch=%0d", c, rst, start, stop, cfg_valid, cfg_half);
         step_cmp($sformatf("rand%0d", c));
      end
      idle_inputs();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
